// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2 K=7 Viterbi decoder datapath.
package viterbi_pkg;

    localparam int unsigned PM_W           = 8;
    localparam int unsigned NORM_THRESH    = 128;
    localparam int unsigned NORM_SUB       = 64;
    localparam int unsigned CONSTRAINT_LEN = 7;
    localparam int unsigned NUM_STATES     = 64;

    // Industry-standard generator pair (octal 171 / 133).
    localparam logic [CONSTRAINT_LEN-1:0] POLY_G0 = 7'o171;
    localparam logic [CONSTRAINT_LEN-1:0] POLY_G1 = 7'o133;

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [1:0]      bm_t;

endpackage

// File: rtl/acs_node.sv
// Combinational add/compare/select with optional normalization and saturation
// for one successor state.
module acs_node
    import viterbi_pkg::*;
#(
    parameter int unsigned MW       = viterbi_pkg::PM_W,
    parameter int unsigned SUB_AMT  = viterbi_pkg::NORM_SUB
) (
    input  logic [MW-1:0] pm_a,
    input  logic [MW-1:0] pm_b,
    input  bm_t           bm_a,
    input  bm_t           bm_b,
    input  logic          norm,
    output logic [MW-1:0] metric_c,
    output logic          dec_c
);

    localparam int unsigned SW = MW + 1;

    logic [SW-1:0] cand_a;
    logic [SW-1:0] cand_b;
    logic [SW-1:0] sel;
    logic [SW-1:0] normed;

    // Ties resolve toward the 2j predecessor (decision 0).
    always_comb begin
        cand_a   = SW'(pm_a) + SW'(bm_a);
        cand_b   = SW'(pm_b) + SW'(bm_b);
        dec_c    = (cand_b < cand_a);
        sel      = dec_c ? cand_b : cand_a;
        normed   = sel;
        if (norm) begin
            normed = (sel >= SW'(SUB_AMT)) ? (sel - SW'(SUB_AMT)) : '0;
        end
        metric_c = normed[MW] ? '1 : normed[MW-1:0];
    end

endmodule

// File: rtl/acs_butterfly.sv
// Registered ACS butterfly: predecessors 2j/2j+1 feed successors j and j+32.
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W        = viterbi_pkg::PM_W,
    parameter int unsigned NORM_THRESH = viterbi_pkg::NORM_THRESH,
    parameter int unsigned NORM_SUB    = viterbi_pkg::NORM_SUB,
    parameter int unsigned INIT_LO     = 0,
    parameter int unsigned INIT_HI     = 63
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            in_valid,
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  bm_t             path_0_bmc,
    input  bm_t             path_1_bmc,
    input  logic            norm_in,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            out_valid,
    output logic            norm_req
);

    localparam int unsigned TW = PM_W + 1;

    logic [PM_W-1:0] lo_c;
    logic [PM_W-1:0] hi_c;
    logic            dec_lo_c;
    logic            dec_hi_c;
    logic            norm_req_c;

    // State j: a takes hypothesis 0, b takes hypothesis 1.
    acs_node #(
        .MW      (PM_W),
        .SUB_AMT (NORM_SUB)
    ) u_node_lo (
        .pm_a     (pm_a),
        .pm_b     (pm_b),
        .bm_a     (path_0_bmc),
        .bm_b     (path_1_bmc),
        .norm     (norm_in),
        .metric_c (lo_c),
        .dec_c    (dec_lo_c)
    );

    // State j+32: hypotheses swap.
    acs_node #(
        .MW      (PM_W),
        .SUB_AMT (NORM_SUB)
    ) u_node_hi (
        .pm_a     (pm_a),
        .pm_b     (pm_b),
        .bm_a     (path_1_bmc),
        .bm_b     (path_0_bmc),
        .norm     (norm_in),
        .metric_c (hi_c),
        .dec_c    (dec_hi_c)
    );

    always_comb begin
        norm_req_c = ({1'b0, lo_c} >= TW'(NORM_THRESH)) ||
                     ({1'b0, hi_c} >= TW'(NORM_THRESH));
    end

    // init outranks in_valid; idle cycles hold everything but out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_lo     <= PM_W'(INIT_LO);
            pm_hi     <= PM_W'(INIT_HI);
            dec_lo    <= 1'b0;
            dec_hi    <= 1'b0;
            out_valid <= 1'b0;
            norm_req  <= 1'b0;
        end else if (init) begin
            pm_lo     <= PM_W'(INIT_LO);
            pm_hi     <= PM_W'(INIT_HI);
            dec_lo    <= 1'b0;
            dec_hi    <= 1'b0;
            out_valid <= 1'b0;
            norm_req  <= 1'b0;
        end else if (in_valid) begin
            pm_lo     <= lo_c;
            pm_hi     <= hi_c;
            dec_lo    <= dec_lo_c;
            dec_hi    <= dec_hi_c;
            out_valid <= 1'b1;
            norm_req  <= norm_req_c;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_butterfly.sv
// Self-checking bench for acs_butterfly: directed table, hand sequences, random vs model.
module tb_acs_butterfly;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic       in_valid;
    logic [7:0] pm_a;
    logic [7:0] pm_b;
    logic [1:0] path_0_bmc;
    logic [1:0] path_1_bmc;
    logic       norm_in;
    logic [7:0] pm_lo;
    logic [7:0] pm_hi;
    logic       dec_lo;
    logic       dec_hi;
    logic       out_valid;
    logic       norm_req;

    int n_vec = 0;
    int n_err = 0;

    // Expected register contents, derived from the arithmetic rules.
    int m_lo, m_hi, m_dlo, m_dhi, m_ov, m_nr;

    typedef struct {
        int a, b, bm0, bm1, nrm;
        int e_lo, e_hi, e_dlo, e_dhi, e_nr;
    } vec_t;

    vec_t tbl[8];

    acs_butterfly dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .in_valid   (in_valid),
        .pm_a       (pm_a),
        .pm_b       (pm_b),
        .path_0_bmc (path_0_bmc),
        .path_1_bmc (path_1_bmc),
        .norm_in    (norm_in),
        .pm_lo      (pm_lo),
        .pm_hi      (pm_hi),
        .dec_lo     (dec_lo),
        .dec_hi     (dec_hi),
        .out_valid  (out_valid),
        .norm_req   (norm_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pm_lo"},     32'(pm_lo),     32'(m_lo));
        chk({tag, ".pm_hi"},     32'(pm_hi),     32'(m_hi));
        chk({tag, ".dec_lo"},    32'(dec_lo),    32'(m_dlo));
        chk({tag, ".dec_hi"},    32'(dec_hi),    32'(m_dhi));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".norm_req"},  32'(norm_req),  32'(m_nr));
    endtask

    function automatic int acs_ref(input int a, input int b, input int bma, input int bmb,
                                   input int nrm, output int dec);
        int ca, cb, s;
        ca  = a + bma;
        cb  = b + bmb;
        dec = (cb < ca) ? 1 : 0;
        s   = dec ? cb : ca;
        if (nrm != 0) s = (s >= 64) ? s - 64 : 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic model_reset();
        m_lo = 0; m_hi = 63; m_dlo = 0; m_dhi = 0; m_ov = 0; m_nr = 0;
    endtask

    // Apply inputs (call just after a falling edge) and advance the model.
    task automatic drive(input int iv, input int ini, input int a, input int b,
                         input int b0, input int b1, input int nrm);
        int d;
        in_valid   = iv[0];
        init       = ini[0];
        pm_a       = 8'(a);
        pm_b       = 8'(b);
        path_0_bmc = 2'(b0);
        path_1_bmc = 2'(b1);
        norm_in    = nrm[0];
        if (ini != 0) begin
            model_reset();
        end else if (iv != 0) begin
            m_lo  = acs_ref(a, b, b0, b1, nrm, d); m_dlo = d;
            m_hi  = acs_ref(a, b, b1, b0, nrm, d); m_dhi = d;
            m_ov  = 1;
            m_nr  = (m_lo >= 128 || m_hi >= 128) ? 1 : 0;
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{10, 12, 2, 0, 0,  12,  10, 0, 0, 0};
        tbl[1] = '{20,  5, 1, 2, 0,   7,   6, 1, 1, 0};
        tbl[2] = '{126, 200, 2, 2, 0, 128, 128, 0, 0, 1};
        tbl[3] = '{130, 140, 0, 0, 1,  66,  66, 0, 0, 0};
        tbl[4] = '{254, 254, 2, 2, 0, 255, 255, 0, 0, 1};
        tbl[5] = '{30,  40, 0, 0, 1,   0,   0, 0, 0, 0};
        tbl[6] = '{0,    0, 2, 2, 0,   2,   2, 0, 0, 0};
        tbl[7] = '{127,  0, 1, 0, 0,   0,   1, 1, 1, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_state("reset_idle");

        // Directed table: constant expectations.
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(1, 0, tbl[i].a, tbl[i].b, tbl[i].bm0, tbl[i].bm1, tbl[i].nrm);
            tick();
            chk($sformatf("tbl%0d.pm_lo", i),     32'(pm_lo),     32'(tbl[i].e_lo));
            chk($sformatf("tbl%0d.pm_hi", i),     32'(pm_hi),     32'(tbl[i].e_hi));
            chk($sformatf("tbl%0d.dec_lo", i),    32'(dec_lo),    32'(tbl[i].e_dlo));
            chk($sformatf("tbl%0d.dec_hi", i),    32'(dec_hi),    32'(tbl[i].e_dhi));
            chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d.norm_req", i),  32'(norm_req),  32'(tbl[i].e_nr));
        end

        // Load a high metric, then idle and a stray norm_in must both hold it.
        @(negedge clk);
        drive(1, 0, 200, 100, 1, 0, 0);
        tick();
        check_state("load_high");
        @(negedge clk);
        drive(0, 0, 5, 5, 0, 0, 0);
        tick();
        check_state("idle_hold");
        @(negedge clk);
        drive(0, 0, 5, 5, 0, 0, 1);
        tick();
        check_state("norm_no_valid");

        // init wins over a simultaneous in_valid.
        @(negedge clk);
        drive(1, 1, 90, 90, 2, 2, 0);
        tick();
        check_state("init_with_valid");
        chk("init.out_valid", 32'(out_valid), 32'd0);
        chk("init.pm_hi", 32'(pm_hi), 32'd63);

        // Reset asserted mid-stream with in_valid held high.
        @(negedge clk);
        drive(1, 0, 150, 160, 0, 1, 0);
        tick();
        check_state("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        tick();
        check_state("rst_held");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 20, 5, 1, 2, 0);
        tick();
        check_state("post_rst");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            drive(($urandom_range(0, 9) < 8) ? 1 : 0,
                  ($urandom_range(0, 19) == 0) ? 1 : 0,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0);
            tick();
            check_state($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acs_butterfly.md
Name: acs_butterfly

Overview:
- Add-compare-select butterfly for the rate-1/2 K=7 (64-state) Viterbi decoder.
- Sits directly downstream of the per-pair branch-metric units.
- Consumes two 2-bit branch metrics (hypothesis 0 and hypothesis 1) plus the path metrics of predecessor states 2j and 2j+1.
- Produces registered path metrics for successor states j and j+32, their survivor decision bits, and a normalization request. Thirty-two instances form one trellis step.

Parameters:
- PM_W, 8, path-metric width in bits (unsigned).
- NORM_THRESH, 128, a registered metric at or above this value raises norm_req.
- NORM_SUB, 64, amount subtracted from the selected metric when norm_in is asserted.
- INIT_LO, 0, reset/init value of pm_lo.
- INIT_HI, 63, reset/init value of pm_hi.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- init  in  1  synchronous reload of INIT_LO/INIT_HI; has priority over in_valid.
- in_valid  in  1  branch and predecessor metrics are valid this cycle.
- pm_a  in  PM_W  path metric of predecessor state 2j.
- pm_b  in  PM_W  path metric of predecessor state 2j+1.
- path_0_bmc  in  2  branch metric, hypothesis 0 (values 0..2).
- path_1_bmc  in  2  branch metric, hypothesis 1 (values 0..2).
- norm_in  in  1  global normalize command, sampled with in_valid.
- pm_lo  out  PM_W  registered metric of state j.
- pm_hi  out  PM_W  registered metric of state j+32.
- dec_lo  out  1  survivor decision for state j (0 = from 2j, 1 = from 2j+1).
- dec_hi  out  1  survivor decision for state j+32.
- out_valid  out  1  outputs updated this cycle.
- norm_req  out  1  registered; pm_lo or pm_hi is at or above NORM_THRESH.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: pm_lo = INIT_LO, pm_hi = INIT_HI.
  - dec_lo, dec_hi, out_valid and norm_req all reset to 0.
- Latency is 1 cycle from in_valid to out_valid. out_valid is a 1-cycle pulse per accepted input. There is no backpressure; a new input is accepted every cycle.
- Candidates, computed in PM_W+1 bits:
  - lo_a = pm_a + path_0_bmc; lo_b = pm_b + path_1_bmc.
  - hi_a = pm_a + path_1_bmc; hi_b = pm_b + path_0_bmc.
- Compare: dec_lo = (lo_b < lo_a). On a tie, select a, giving decision 0. The same rule applies to hi.
- Normalization: if norm_in is asserted with in_valid, subtract NORM_SUB from the selected value. The result floors at 0.
- Saturation: a result above 2^PM_W−1 clamps to 2^PM_W−1.
- Order of operations: select, then normalize, then saturate.
- norm_req is computed from the newly registered metrics and is updated only when registers load.
- init behaviour:
  - Loads INIT_LO/INIT_HI and clears dec_lo, dec_hi and norm_req.
  - out_valid is 0 on the init cycle.
  - Any in_valid on the same cycle is dropped.
- When in_valid = 0 and init = 0: all registers hold and out_valid = 0.
- norm_in without in_valid is ignored.
- Reset asserted mid-stream forces the reset values immediately. The first in_valid after deassertion is processed normally.

Decomposition:
- Shared package viterbi_pkg holds:
  - PM_W, NORM_THRESH, NORM_SUB;
  - the state count (64) and constraint length (7);
  - the generator polynomials;
  - typedef pm_t (logic [PM_W-1:0]) and bm_t (logic [1:0]).
- One natural sub-module, acs_node: a combinational add/compare/select/normalize/saturate slice, instantiated twice (lo and hi) under the registered wrapper.

Test Plan:
- Reset, then idle → pm_lo=0, pm_hi=63, dec_lo=0, dec_hi=0, out_valid=0, norm_req=0.
- pm_a=10, pm_b=12, bm0=2, bm1=0, in_valid → next cycle pm_lo=12 with dec_lo=0 (tie, a wins); pm_hi=10 with dec_hi=0; out_valid=1.
- pm_a=20, pm_b=5, bm0=1, bm1=2, in_valid → pm_lo=7 with dec_lo=1; pm_hi=6 with dec_hi=1.
- pm_a=126, pm_b=200, bm0=2, bm1=2 → pm_lo=pm_hi=128, dec=0, norm_req=1. Next step pm_a=130, pm_b=140, bm=0/0, norm_in=1 → pm_lo=66, pm_hi=66, norm_req=0.
- pm_a=pm_b=254, bm0=bm1=2, no norm → pm_lo=pm_hi=255 (saturated), norm_req=1. Repeat with pm_a=30, pm_b=40, bm=0/0, norm_in=1 → pm_lo=pm_hi=0 (floored).
- init and in_valid asserted in the same cycle → out_valid=0, pm_lo=0, pm_hi=63. Assert rst mid-stream with in_valid held high → outputs take reset values asynchronously and resume 1 cycle after release.
